tree_fanin_collector: RTL



---
 rtl/tree_fanin_pkg.sv | 23 ++
 rtl/tree_fanin_rr_arb.sv | 33 +++
 rtl/tree_fanin_collector.sv | 136 +++++++++++++
 3 files changed

// File: rtl/tree_fanin_pkg.sv
// Shared constants, index helpers and the upstream beat type for the tree fan-in collector.
package tree_fanin_pkg;

    localparam int DEF_NUM_CHILDREN = 5;
    localparam int DEF_DATA_W       = 16;

    // Source tag width; never narrower than one bit.
    function automatic int src_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_SRC_W = src_w(DEF_NUM_CHILDREN);

    function automatic int wrap_idx(input int idx, input int n);
        return idx % n;
    endfunction

    typedef struct packed {
        logic [DEF_SRC_W-1:0]  src;
        logic [DEF_DATA_W-1:0] data;
    } beat_t;

endpackage

// File: rtl/tree_fanin_rr_arb.sv
// Combinational round-robin arbiter: scans requests starting at the pointer, wrapping modulo N.
module tree_fanin_rr_arb
    import tree_fanin_pkg::*;
#(
    parameter int N     = DEF_NUM_CHILDREN,
    parameter int IDX_W = src_w(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    logic w_found;

    always_comb begin
        // NOTE: every output gets a default first, so no path through the loop can infer a latch.
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!w_found && i_req[wrap_idx(int'(i_ptr) + k, N)]) begin
                w_found = 1'b1;
                o_gnt[wrap_idx(int'(i_ptr) + k, N)] = 1'b1;
                o_idx = IDX_W'(wrap_idx(int'(i_ptr) + k, N));
            end
        end
    end

    assign o_any = w_found;

endmodule

// File: rtl/tree_fanin_collector.sv
// Tree fan-in collector: one hold register per child, round-robin merge into one tagged upstream stream.
// Optional even-parity output enabled by defining TREE_FANIN_PARITY_EN.
module tree_fanin_collector
    import tree_fanin_pkg::*;
#(
    parameter int NUM_CHILDREN = DEF_NUM_CHILDREN,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int SRC_W        = src_w(NUM_CHILDREN)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_CHILDREN-1:0]        child_valid,
    output logic [NUM_CHILDREN-1:0]        child_ready,
    input  logic [NUM_CHILDREN*DATA_W-1:0] child_data,
    output logic                           up_valid,
    input  logic                           up_ready,
    output logic [DATA_W-1:0]              up_data,
    output logic [SRC_W-1:0]               up_src,
    output logic [15:0]                    up_count
`ifdef TREE_FANIN_PARITY_EN
    ,
    output logic                           up_parity
`endif
);

    typedef struct packed {
        logic [SRC_W-1:0]  src;
        logic [DATA_W-1:0] data;
    } out_beat_t;

    logic [NUM_CHILDREN-1:0] r_hold_valid;
    logic [DATA_W-1:0]       r_hold_data [NUM_CHILDREN];
    out_beat_t               r_out;
    logic                    r_out_valid;
    logic [SRC_W-1:0]        r_rr_ptr;
    logic [15:0]             r_up_count;

    logic [NUM_CHILDREN-1:0] w_gnt;
    logic [SRC_W-1:0]        w_gnt_idx;
    logic                    w_gnt_any;
    logic                    w_out_free;
    logic                    w_load;
    logic                    w_pop;
    logic [DATA_W-1:0]       w_sel_data;

    assign w_out_free = ~r_out_valid | up_ready;
    assign w_load     = w_out_free & w_gnt_any;
    assign w_pop      = r_out_valid & up_ready;
    assign w_sel_data = r_hold_data[w_gnt_idx];

    tree_fanin_rr_arb #(
        .N     (NUM_CHILDREN),
        .IDX_W (SRC_W)
    ) u_arb (
        .i_req (r_hold_valid),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_gnt_idx),
        .o_any (w_gnt_any)
    );

    // A granted hold had child_ready low, so clear and refill never collide on one entry.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_hold_valid <= '0;
        end else begin
            for (int i = 0; i < NUM_CHILDREN; i++) begin
                if (w_load && w_gnt[i]) begin
                    r_hold_valid[i] <= 1'b0;
                end else if (child_valid[i] && !r_hold_valid[i]) begin
                    r_hold_valid[i] <= 1'b1;
                end
            end
        end
    end

    // NOTE: payload storage is not reset; hold_valid qualifies it and reset clears that.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CHILDREN; i++) begin
            if (child_valid[i] && !r_hold_valid[i]) begin
                r_hold_data[i] <= child_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out.src   <= w_gnt_idx;
            r_out.data  <= w_sel_data;
        end else if (w_pop) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_load) begin
            r_rr_ptr <= SRC_W'(wrap_idx(int'(w_gnt_idx) + 1, NUM_CHILDREN));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_up_count <= '0;
        end else if (w_pop) begin
            r_up_count <= r_up_count + 16'd1;
        end
    end

`ifdef TREE_FANIN_PARITY_EN
    logic r_parity;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_parity <= 1'b0;
        end else if (w_load) begin
            r_parity <= ^{w_gnt_idx, w_sel_data};
        end
    end

    assign up_parity = r_parity;
`endif

    assign child_ready = ~r_hold_valid;
    assign up_valid    = r_out_valid;
    assign up_data     = r_out.data;
    assign up_src      = r_out.src;
    assign up_count    = r_up_count;

endmodule
